// File: rtl/reservation_station.sv
// Reservation station: parks ALU-class ops until both operands are valid, snooping both CDBs,
// and issues the lowest-index ready entry to the ALU each cycle; flush discards all entries.
module reservation_station #(
    parameter int RS_WIDTH  = 2,
    parameter int RoB_WIDTH = 3,
    parameter int NON_DEP   = 1 << RoB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 new_entry_en,
    input  logic [RoB_WIDTH-1:0] new_rob_index,
    input  logic [6:0]           new_opcode,
    input  logic [31:0]          new_Vj,
    input  logic [31:0]          new_Vk,
    input  logic [RoB_WIDTH:0]   new_Qj,
    input  logic [RoB_WIDTH:0]   new_Qk,
    input  logic [31:0]          new_imm,
    input  logic [31:0]          new_pc,
    output logic                 is_full,
    input  logic                 alu_cdb_en,
    input  logic [RoB_WIDTH-1:0] alu_cdb_rob_index,
    input  logic [31:0]          alu_cdb_value,
    input  logic                 lsb_cdb_en,
    input  logic [RoB_WIDTH-1:0] lsb_cdb_rob_index,
    input  logic [31:0]          lsb_cdb_value,
    input  logic                 flush,
    output logic                 alu_en,
    output logic [RoB_WIDTH-1:0] alu_rob_index,
    output logic [6:0]           alu_opcode,
    output logic [31:0]          alu_Vj,
    output logic [31:0]          alu_Vk,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc
);
    localparam int SIZE = 1 << RS_WIDTH;
    localparam logic [RoB_WIDTH:0] ND_TAG = NON_DEP[RoB_WIDTH:0];

    typedef struct packed {
        logic [RoB_WIDTH:0] q;
        logic [31:0]        v;
    } opnd_t;

    logic                 busy   [SIZE];
    logic [RoB_WIDTH-1:0] e_rob  [SIZE];
    logic [6:0]           e_op   [SIZE];
    opnd_t                e_j    [SIZE];
    opnd_t                e_k    [SIZE];
    logic [31:0]          e_imm  [SIZE];
    logic [31:0]          e_pc   [SIZE];

    logic [RoB_WIDTH:0]   alu_tag;
    logic [RoB_WIDTH:0]   lsb_tag;
    logic                 iss_hit;
    logic [RS_WIDTH-1:0]  iss_idx;
    logic                 ins_hit;
    logic [RS_WIDTH-1:0]  ins_idx;
    logic                 ins_do;
    logic [RS_WIDTH:0]    free_cnt;
    logic [RS_WIDTH:0]    free_next;
    opnd_t                new_j;
    opnd_t                new_k;

    // Bus tags carry a zero top bit so a NON_DEP operand can never match.
    assign alu_tag = {1'b0, alu_cdb_rob_index};
    assign lsb_tag = {1'b0, lsb_cdb_rob_index};

    function automatic opnd_t snoop(input opnd_t o);
        opnd_t r;
        r = o;
        if (alu_cdb_en && o.q == alu_tag) begin
            r.q = ND_TAG;
            r.v = alu_cdb_value;
        end else if (lsb_cdb_en && o.q == lsb_tag) begin
            r.q = ND_TAG;
            r.v = lsb_cdb_value;
        end
        return r;
    endfunction

    always_comb begin
        iss_hit  = 1'b0;
        iss_idx  = '0;
        ins_hit  = 1'b0;
        ins_idx  = '0;
        free_cnt = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (busy[i] && e_j[i].q == ND_TAG && e_k[i].q == ND_TAG) begin
                iss_hit = 1'b1;
                iss_idx = RS_WIDTH'(i);
            end
            if (!busy[i]) begin
                ins_hit = 1'b1;
                ins_idx = RS_WIDTH'(i);
            end
            free_cnt = free_cnt + (RS_WIDTH+1)'(!busy[i]);
        end
        ins_do    = new_entry_en && ins_hit;
        free_next = free_cnt - (RS_WIDTH+1)'(ins_do) + (RS_WIDTH+1)'(iss_hit);
        new_j     = snoop('{q: new_Qj, v: new_Vj});
        new_k     = snoop('{q: new_Qk, v: new_Vk});
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < SIZE; i++) begin
                busy[i]  <= 1'b0;
                e_rob[i] <= '0;
                e_op[i]  <= '0;
                e_j[i]   <= '0;
                e_k[i]   <= '0;
                e_imm[i] <= '0;
                e_pc[i]  <= '0;
            end
            alu_en        <= 1'b0;
            alu_rob_index <= '0;
            alu_opcode    <= '0;
            alu_Vj        <= '0;
            alu_Vk        <= '0;
            alu_imm       <= '0;
            alu_pc        <= '0;
            is_full       <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                for (int i = 0; i < SIZE; i++) busy[i] <= 1'b0;
                alu_en  <= 1'b0;
                is_full <= 1'b0;
            end else begin
                for (int i = 0; i < SIZE; i++) begin
                    if (busy[i]) begin
                        e_j[i] <= snoop(e_j[i]);
                        e_k[i] <= snoop(e_k[i]);
                    end
                end
                alu_en <= iss_hit;
                if (iss_hit) begin
                    busy[iss_idx] <= 1'b0;
                    alu_rob_index <= e_rob[iss_idx];
                    alu_opcode    <= e_op[iss_idx];
                    alu_Vj        <= e_j[iss_idx].v;
                    alu_Vk        <= e_k[iss_idx].v;
                    alu_imm       <= e_imm[iss_idx];
                    alu_pc        <= e_pc[iss_idx];
                end
                // Slot choice uses pre-edge busy, so a slot freed by this issue stays empty.
                if (ins_do) begin
                    busy[ins_idx]  <= 1'b1;
                    e_rob[ins_idx] <= new_rob_index;
                    e_op[ins_idx]  <= new_opcode;
                    e_j[ins_idx]   <= new_j;
                    e_k[ins_idx]   <= new_k;
                    e_imm[ins_idx] <= new_imm;
                    e_pc[ins_idx]  <= new_pc;
                end
                is_full <= free_next < (RS_WIDTH+1)'(2);
            end
        end
    end
endmodule
